// File: rtl/j2c_arbiter.sv
// Round-robin arbiter that shares one J2C serial master between NUM_REQ requesters,
// with an inter-frame gap and a completion watchdog. All outputs are registered.
module j2c_arbiter #(
    parameter int MESSAGE_LENGTH = 8,
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                ack,
    output logic [MESSAGE_LENGTH-1:0]         tx_data,
    output logic                              tx_start,
    input  logic                              tx_done,
    output logic                              timeout,
    output logic                              idle,
    output logic [1:0]                        fsm_state
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                    state, state_d;
    logic [IW-1:0]             last, last_d;
    logic [IW-1:0]             owner, owner_d;
    logic [IW-1:0]             pick, idx;
    logic                      pick_found;
    logic [CW-1:0]             cnt, cnt_d;
    logic [NUM_REQ-1:0]        grant_d, ack_d, onehot_pick;
    logic [MESSAGE_LENGTH-1:0] tx_data_d;
    logic                      tx_start_d, timeout_d;

    // First requester above the last one served, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IW'((int'(last) + off) % NUM_REQ);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    assign onehot_pick = NUM_REQ'(1) << pick;

    always_comb begin
        state_d    = state;
        last_d     = last;
        owner_d    = owner;
        cnt_d      = cnt;
        grant_d    = grant;
        ack_d      = '0;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_START;
                    owner_d    = pick;
                    grant_d    = onehot_pick;
                    tx_data_d  = req_data[int'(pick)*MESSAGE_LENGTH +: MESSAGE_LENGTH];
                    tx_start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A completion on the same edge as the watchdog expiry still counts as success.
                if (tx_done || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    ack_d     = tx_done ? grant : '0;
                    timeout_d = !tx_done;
                    last_d    = owner;
                    grant_d   = '0;
                    cnt_d     = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            last     <= IW'(NUM_REQ - 1);
            owner    <= '0;
            cnt      <= '0;
            grant    <= '0;
            ack      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            idle     <= 1'b1;
        end else begin
            state    <= state_d;
            last     <= last_d;
            owner    <= owner_d;
            cnt      <= cnt_d;
            grant    <= grant_d;
            ack      <= ack_d;
            tx_data  <= tx_data_d;
            tx_start <= tx_start_d;
            timeout  <= timeout_d;
            idle     <= (state_d == S_IDLE);
        end
    end

    assign fsm_state = state;

endmodule
